// File: rtl/ddr_pkg.sv
// Shared types and constants for the dance-pad input front end.
package ddr_pkg;

  localparam int N_BTN_DEFAULT = 4;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    PEND_HIGH = 2'd1,
    HIGH      = 2'd2,
    PEND_LOW  = 2'd3
  } debounce_state_t;

  // A channel reads as pressed once it has committed high, including while a release is pending.
  function automatic logic is_pressed(input logic [1:0] st);
    return (st == HIGH) || (st == PEND_LOW);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM and hold counter.
// The FSM state is the only output; the level is decoded by the caller.
module debounce_channel
  import ddr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw_i,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            sync1_q, sync2_q;
  logic            s;
  debounce_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign s       = sync2_q;
  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An input returning to its old value aborts the pending interval with the count cleared.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOW: begin
        if (s) begin
          state_d = PEND_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PEND_HIGH: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = PEND_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_LOW: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BTN independent pad inputs into clean levels plus an any-pressed flag.
module button_debouncer
  import ddr_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             any_pressed
);

  logic [1:0] ch_state [N_BTN];

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_raw_i(btn_raw[i]),
      .state_o  (ch_state[i])
    );
    assign btn_level[i] = is_pressed(ch_state[i]);
  end

  // Pure OR of state-decoded bits, so no raw input can reach this flag.
  assign any_pressed = |btn_level;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES = 4, N_BTN = 4.
module tb_button_debouncer;

  localparam int N  = 4;
  localparam int DC = 4;
  localparam int W  = N + 1;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic         any_pressed;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  int           step_no;

  button_debouncer #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .any_pressed(any_pressed)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset   = 1'b0;
    btn_raw = '0;
  end

  // Driver: drive on the falling edge, expected outputs are those after the next rising edge.
  task automatic run(input logic [N-1:0] raw, input logic rst_n,
                     input logic [N-1:0] exp_lvl, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      btn_raw = raw;
      reset   = rst_n;
      exp_q.push_back({|exp_lvl, exp_lvl});
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_no++;
      checks++;
      if (btn_level !== e[N-1:0]) begin
        errors++;
        $display("FAIL level step %0d: got %b expected %b", step_no, btn_level, e[N-1:0]);
      end
      checks++;
      if (any_pressed !== e[N]) begin
        errors++;
        $display("FAIL any_pressed step %0d: got %b expected %b", step_no, any_pressed, e[N]);
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;

    // Reset held with all buttons pressed, then press seen as new after release
    run(4'b1111, 1'b0, 4'b0000, 3);
    run(4'b1111, 1'b1, 4'b0000, 5);
    run(4'b1111, 1'b1, 4'b1111, 3);
    run(4'b0000, 1'b1, 4'b1111, 5);
    run(4'b0000, 1'b1, 4'b0000, 3);

    // Clean press on channel 0
    run(4'b0001, 1'b1, 4'b0000, 5);
    run(4'b0001, 1'b1, 4'b0001, 3);
    run(4'b0000, 1'b1, 4'b0001, 5);
    run(4'b0000, 1'b1, 4'b0000, 2);

    // Bounce on channel 1: 1,0,1,1,0,1 then hold
    run(4'b0010, 1'b1, 4'b0000, 1);
    run(4'b0000, 1'b1, 4'b0000, 1);
    run(4'b0010, 1'b1, 4'b0000, 2);
    run(4'b0000, 1'b1, 4'b0000, 1);
    run(4'b0010, 1'b1, 4'b0000, 5);
    run(4'b0010, 1'b1, 4'b0010, 3);
    run(4'b0000, 1'b1, 4'b0010, 5);
    run(4'b0000, 1'b1, 4'b0000, 2);

    // Release glitch on channel 2, then sustained release
    run(4'b0100, 1'b1, 4'b0000, 5);
    run(4'b0100, 1'b1, 4'b0100, 2);
    run(4'b0000, 1'b1, 4'b0100, 3);
    run(4'b0100, 1'b1, 4'b0100, 4);
    run(4'b0000, 1'b1, 4'b0100, 5);
    run(4'b0000, 1'b1, 4'b0000, 2);

    // Simultaneous press and release
    run(4'b1111, 1'b1, 4'b0000, 5);
    run(4'b1111, 1'b1, 4'b1111, 2);
    run(4'b0000, 1'b1, 4'b1111, 5);
    run(4'b0000, 1'b1, 4'b0000, 2);

    // Channel 3 staggered by 2 cycles
    run(4'b0111, 1'b1, 4'b0000, 2);
    run(4'b1111, 1'b1, 4'b0000, 3);
    run(4'b1111, 1'b1, 4'b0111, 2);
    run(4'b1111, 1'b1, 4'b1111, 2);
    run(4'b0000, 1'b1, 4'b1111, 5);
    run(4'b0000, 1'b1, 4'b0000, 2);

    // Reset at edge 3 of a pending press restarts the full latency
    run(4'b0001, 1'b1, 4'b0000, 3);
    run(4'b0001, 1'b0, 4'b0000, 1);
    run(4'b0001, 1'b1, 4'b0000, 5);
    run(4'b0001, 1'b1, 4'b0001, 2);

    // Reset while high clears the level on the next edge
    run(4'b0001, 1'b0, 4'b0000, 1);
    run(4'b0000, 1'b1, 4'b0000, 3);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
